// File: rtl/wb_master_ctrl.sv
// Single-transfer Wishbone classic master: one fabric command in, one rsp_valid_o pulse out per bus cycle.
// Strobe is visible the cycle after accept; cmd_ready_o stays low while busy or while the slave still drives ack/err.
module wb_master_ctrl #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,

    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_we_i,
    input  logic [BUS_DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0]   cmd_dat_i,

    output logic                        rsp_valid_o,
    output logic [BUS_DATA_WIDTH-1:0]   rsp_dat_o,
    output logic                        rsp_err_o,
    output logic                        rsp_tout_o,
    output logic                        busy_o,

    output logic                        wbm_cyc_o,
    output logic                        wbm_stb_o,
    output logic                        wbm_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                        wbm_ack_i,
    input  logic                        wbm_err_i
);

    localparam int SEL_W = BUS_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]                r_state;
    logic [15:0]               r_tout_cnt;
    logic                      r_busy;

    logic                      r_cyc;
    logic                      r_stb;
    logic                      r_we;
    logic [SEL_W-1:0]          r_sel;
    logic [BUS_ADDR_WIDTH-1:0] r_adr;
    logic [BUS_DATA_WIDTH-1:0] r_dat;

    logic                      r_rsp_vld;
    logic [BUS_DATA_WIDTH-1:0] r_rsp_dat;
    logic                      r_rsp_err;
    logic                      r_rsp_tout;

    logic                      w_slave_resp;
    logic                      w_accept;
    logic                      w_tout_hit;
    logic                      w_rd_capture;

    assign w_slave_resp = wbm_ack_i | wbm_err_i;

    // Ready qualifies the registered IDLE state with the live ack/err so a lingering slave response blocks acceptance.
    assign cmd_ready_o  = (r_state == ST_IDLE) & ~w_slave_resp & ~wb_rst_i;
    assign w_accept     = cmd_valid_i & cmd_ready_o;
    assign w_tout_hit   = (r_tout_cnt == TOUT_LAST);
    assign w_rd_capture = wbm_ack_i & ~wbm_err_i & ~r_we;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_tout_cnt <= 16'd0;
            r_busy     <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_dat  <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_tout <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= cmd_we_i;
                        r_sel      <= cmd_sel_i;
                        r_adr      <= cmd_adr_i;
                        r_dat      <= cmd_dat_i;
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_tout_cnt <= 16'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (w_slave_resp) begin
                        // err outranks ack; read data is only taken from a clean ack
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_rsp_vld  <= 1'b1;
                        r_rsp_err  <= wbm_err_i;
                        r_rsp_tout <= 1'b0;
                        if (w_rd_capture) begin
                            r_rsp_dat <= wbm_dat_i;
                        end
                        r_state    <= ST_DRAIN;
                    end else if (w_tout_hit) begin
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_rsp_vld  <= 1'b1;
                        r_rsp_err  <= 1'b1;
                        r_rsp_tout <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_tout_cnt <= r_tout_cnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!w_slave_resp) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

    assign rsp_valid_o = r_rsp_vld;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_tout_o  = r_rsp_tout;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: configurable slave, scoreboard queue filled at accept, monitor checks each rsp pulse.
module tb_wb_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [SW-1:0] cmd_sel_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic          rsp_valid_o, rsp_err_o, rsp_tout_o, busy_o;
    logic [DW-1:0] rsp_dat_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic          wbm_ack_i, wbm_err_i;

    logic sl_ack = 1'b0, sl_err = 1'b0, stray_ack = 1'b0, stray_err = 1'b0;
    assign wbm_ack_i = sl_ack | stray_ack;
    assign wbm_err_i = sl_err | stray_err;

    // slave behaviour for the current transfer: 0 ack, 1 err, 2 ack+err, 3 silent
    int cfg_resp = 0, cfg_delay = 0, cfg_hold = 0;
    logic [DW-1:0] sl_mem [0:255];
    assign wbm_dat_i = sl_mem[wbm_adr_o];

    typedef struct {
        logic        err;
        logic        tout;
        logic [31:0] dat;
        int          lat;
        int          stbn;
        logic [44:0] fields;
        int          acc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_mem [0:255];
    logic [DW-1:0] m_last = '0;

    int n_tests = 0, n_fail = 0;
    int cyc_cnt = 0, last_rsp_cyc = 0, bus_tx = 0, n_accept = 0, viol = 0;
    int prev_gap = 1;
    bit have_prev = 0;

    wb_master_ctrl #(.BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_tout_o(rsp_tout_o), .busy_o(busy_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", sbq.size());
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Slave: responds at stb cycle index cfg_delay, keeps the response cfg_hold cycles after stb falls.
    initial begin : slave
        int k;
        bit in_tx;
        bit asserted;
        int hold_left;
        k = 0; in_tx = 0; asserted = 0; hold_left = 0;
        forever begin
            @(posedge clk); #1;
            if (wbm_cyc_o && wbm_stb_o) begin
                k = in_tx ? k + 1 : 0;
                in_tx = 1;
                if (cfg_resp != 3 && k >= cfg_delay) begin
                    if (!asserted && cfg_resp == 0 && wbm_we_o)
                        for (int b = 0; b < SW; b++)
                            if (wbm_sel_o[b]) sl_mem[wbm_adr_o][8*b +: 8] = wbm_dat_o[8*b +: 8];
                    asserted  = 1;
                    hold_left = cfg_hold;
                end
            end else begin
                in_tx = 0;
                if (asserted && hold_left > 0) hold_left--;
                else asserted = 0;
            end
            sl_ack = asserted && (cfg_resp != 1);
            sl_err = asserted && (cfg_resp != 0);
        end
    end

    // Monitor: protocol rules every cycle, scoreboard compare on every rsp pulse.
    initial begin : monitor
        int          stb_cnt;
        logic [44:0] cap;
        bit          unstable;
        exp_t        e;
        stb_cnt = 0; unstable = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (cmd_ready_o && (wbm_ack_i || wbm_err_i || wbm_cyc_o || busy_o || rst)) viol++;
            if (wbm_cyc_o != wbm_stb_o) viol++;
            if (wbm_cyc_o && !busy_o) viol++;
            if (rst) begin
                stb_cnt = 0;
                unstable = 0;
            end else begin
                if (wbm_stb_o) begin
                    if (stb_cnt == 0) begin
                        cap = {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
                        bus_tx++;
                    end else if ({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} != cap) begin
                        unstable = 1;
                    end
                    stb_cnt++;
                end
                if (rsp_valid_o) begin
                    last_rsp_cyc = cyc_cnt;
                    if (sbq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: rsp_valid_o with no outstanding command at cycle %0d", cyc_cnt);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                        check("rsp_tout", 64'(rsp_tout_o), 64'(e.tout));
                        check("rsp_dat", 64'(rsp_dat_o), 64'(e.dat));
                        check("accept_to_rsp_latency", 64'(cyc_cnt - e.acc), 64'(e.lat));
                        check("stb_cycles", 64'(stb_cnt), 64'(e.stbn));
                        check("bus_fields", 64'(cap), 64'(e.fields));
                        check("bus_fields_stable", 64'(unstable), 64'(0));
                    end
                    stb_cnt = 0;
                    unstable = 0;
                end
            end
        end
    end

    // Drive one command; expected response comes from the reference rules at the accept edge.
    task automatic issue(input logic we, input logic [3:0] sel, input logic [7:0] adr,
                         input logic [31:0] dat, input int resp, input int delay,
                         input int hold, input bit held);
        exp_t e;
        int   waitc;
        bit   tmo;
        cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
        cmd_valid_i = 1'b1;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!cmd_ready_o && waitc < 200);
        if (!cmd_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_wait: cmd_ready_o still low after %0d cycles", waitc);
            cmd_valid_i = 1'b0;
            return;
        end
        if (held && have_prev)
            check("accept_gap_after_rsp", 64'(cyc_cnt - last_rsp_cyc), 64'(prev_gap));
        cfg_resp = resp; cfg_delay = delay; cfg_hold = hold;
        tmo = (resp == 3) || (delay >= TO);
        e.acc    = cyc_cnt;
        e.fields = {we, sel, adr, dat};
        if (tmo) begin
            e.err = 1'b1; e.tout = 1'b1; e.lat = TO + 1; e.stbn = TO;
        end else begin
            e.err = (resp != 0); e.tout = 1'b0; e.lat = delay + 2; e.stbn = delay + 1;
            if (resp == 0) begin
                if (we) begin
                    for (int b = 0; b < SW; b++)
                        if (sel[b]) m_mem[adr][8*b +: 8] = dat[8*b +: 8];
                end else begin
                    m_last = m_mem[adr];
                end
            end
        end
        e.dat = m_last;
        sbq.push_back(e);
        n_accept++;
        prev_gap  = tmo ? 1 : 1 + hold;
        have_prev = 1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sbq.size() != 0 || busy_o || wbm_ack_i || wbm_err_i) && n < 300);
        if (sbq.size() != 0 || busy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait: busy after %0d cycles, %0d responses outstanding", n, sbq.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            sl_mem[a] = init_word(a);
            m_mem[a]  = init_word(a);
        end
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = '0; cmd_adr_i = '0; cmd_dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_outputs", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
                                         rsp_valid_o, rsp_err_o, rsp_tout_o, busy_o}), 64'(0));
        check("reset_wbm_dat", 64'(wbm_dat_o), 64'(0));
        check("reset_rsp_dat", 64'(rsp_dat_o), 64'(0));
        check("reset_ready_low", 64'(cmd_ready_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready_o), 64'(1));
        @(posedge clk); #1;

        // write then read back, slave holding ack until stb falls
        issue(1'b1, 4'hF, 8'h00, 32'hDEADBEEF, 0, 1, 1, 1'b0);
        issue(1'b0, 4'hF, 8'h00, 32'h0, 0, 1, 1, 1'b1);
        wait_idle();
        check("read_back_deadbeef", 64'(rsp_dat_o), 64'(32'hDEADBEEF));

        // err together with ack must leave read data untouched
        issue(1'b0, 4'hF, 8'h01, 32'h0, 2, 1, 0, 1'b0);
        wait_idle();
        check("err_keeps_rsp_dat", 64'(rsp_dat_o), 64'(32'hDEADBEEF));

        // silent slave times out; next command held ready behind it
        issue(1'b1, 4'hF, 8'h05, 32'h12345678, 3, 0, 0, 1'b0);
        issue(1'b1, 4'h3, 8'h06, 32'hCAFEF00D, 0, 1, 0, 1'b1);
        // ack on the timeout edge wins
        issue(1'b0, 4'hF, 8'h06, 32'h0, 0, TO - 1, 0, 1'b1);
        // back-to-back writes with valid held
        issue(1'b1, 4'hF, 8'h07, 32'h11111111, 0, 1, 0, 1'b1);
        issue(1'b1, 4'h5, 8'h08, 32'h22222222, 0, 0, 0, 1'b1);
        issue(1'b1, 4'hA, 8'h09, 32'h33333333, 0, 2, 0, 1'b1);
        wait_idle();

        // stray ack/err in idle: no response, no acceptance
        stray_ack = 1'b1;
        @(negedge clk);
        check("stray_ack_blocks_ready", 64'(cmd_ready_o), 64'(0));
        @(posedge clk); #1;
        stray_ack = 1'b0; stray_err = 1'b1;
        @(negedge clk);
        check("stray_err_blocks_ready", 64'(cmd_ready_o), 64'(0));
        check("stray_no_busy", 64'(busy_o), 64'(0));
        @(posedge clk); #1;
        stray_err = 1'b0;
        @(negedge clk);
        check("ready_after_stray", 64'(cmd_ready_o), 64'(1));
        @(posedge clk); #1;

        // reset during the second BUS cycle
        issue(1'b1, 4'hF, 8'h0A, 32'hA5A5A5A5, 3, 0, 0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        m_last = '0;
        have_prev = 0;
        @(negedge clk);
        check("ready_low_in_reset", 64'(cmd_ready_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midtx_reset_bus_idle", 64'({wbm_cyc_o, wbm_stb_o, busy_o, rsp_valid_o}), 64'(0));
        check("midtx_reset_rsp_dat", 64'(rsp_dat_o), 64'(0));
        check("ready_after_midtx_reset", 64'(cmd_ready_o), 64'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            int r, gap, resp;
            gap = $urandom_range(0, 3);
            if (gap > 1) begin
                repeat (gap - 1) begin
                    @(posedge clk); #1;
                end
            end
            r = $urandom_range(0, 19);
            resp = (r < 12) ? 0 : (r < 15) ? 1 : (r < 17) ? 2 : 3;
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 8'($urandom_range(0, 15)),
                  $urandom, resp, $urandom_range(0, 5), $urandom_range(0, 2), gap <= 1);
        end
        wait_idle();

        check("bus_cycles_equal_accepts", 64'(bus_tx), 64'(n_accept));
        check("ready_rule_violations", 64'(viol), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
